pattern_gen: RTL and testbench

//   Parametrised test-pattern source, successor to the fixed 0/constant toggler.

---
 rtl/pattern_gen_if.sv | 11 +
 rtl/pattern_gen.sv | 185 ++++++++++++++++++
 tb/tb_pattern_gen.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_gen_if.sv
// Sample stream between pattern_gen and its consumer: data/valid forward, ready back.
interface pattern_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pattern_gen.sv
// Test-pattern source: TOGGLE / RAMP / HOLD / LFSR samples over a valid/ready stream
// with a programmable idle gap between an accepted sample and the next one.
module pattern_gen #(
    parameter int               WIDTH    = 8,
    parameter int               PERIOD_W = 8,
    parameter int               CNT_W    = 16,
    parameter int               STEP     = 1,
    parameter logic [WIDTH-1:0] TAPS     = 8'hB8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic [WIDTH-1:0]    low_val,
    input  logic [WIDTH-1:0]    high_val,
    pattern_gen_if.master       strm,
    output logic                busy,
    output logic [CNT_W-1:0]    sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_WAIT    = 2'd2
    } state_t;

    localparam logic [1:0]          M_TOGGLE = 2'd0;
    localparam logic [1:0]          M_RAMP   = 2'd1;
    localparam logic [1:0]          M_HOLD   = 2'd2;
    localparam logic [1:0]          M_LFSR   = 2'd3;
    localparam logic [WIDTH:0]      STEP_X   = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0]    DATA_ONE = {{(WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] GAP_ONE  = {{(PERIOD_W - 1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W - 1){1'b0}}, 1'b1};

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_data, w_data_nxt;
    logic [PERIOD_W-1:0] r_gap, w_gap_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_valid;
    logic                r_busy;
    logic                w_load_cfg;
    logic [1:0]          r_mode;
    logic [PERIOD_W-1:0] r_period;
    logic [WIDTH-1:0]    r_low;
    logic [WIDTH-1:0]    r_high;

    function automatic logic [WIDTH-1:0] first_sample(
        input logic [1:0]       m,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi
    );
        case (m)
            M_TOGGLE: first_sample = lo;
            M_RAMP:   first_sample = lo;
            M_HOLD:   first_sample = hi;
            M_LFSR:   first_sample = (lo == '0) ? DATA_ONE : lo;
            default:  first_sample = lo;
        endcase
    endfunction

    // RAMP sums one bit wider so data+STEP cannot wrap before the limit compare.
    function automatic logic [WIDTH-1:0] next_sample(
        input logic [WIDTH-1:0] cur,
        input logic [1:0]       m,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi
    );
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] shifted;
        sum     = {1'b0, cur} + STEP_X;
        shifted = {cur[WIDTH-2:0], ^(cur & TAPS)};
        case (m)
            M_TOGGLE: next_sample = (cur == lo) ? hi : lo;
            M_RAMP:   next_sample = (sum > {1'b0, hi}) ? lo : sum[WIDTH-1:0];
            M_HOLD:   next_sample = hi;
            M_LFSR:   next_sample = (shifted == '0) ? DATA_ONE : shifted;
            default:  next_sample = lo;
        endcase
    endfunction

    // Next-state, next-sample, gap and counter decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_gap_nxt   = r_gap;
        w_cnt_nxt   = r_cnt;
        w_load_cfg  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_load_cfg  = 1'b1;
                    w_data_nxt  = first_sample(mode, low_val, high_val);
                    w_state_nxt = S_PRESENT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PRESENT: begin
                if (strm.ready) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (!en) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_period == '0) begin
                        w_data_nxt = next_sample(r_data, r_mode, r_low, r_high);
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_gap_nxt   = r_period;
                    end
                end else begin
                    w_state_nxt = S_PRESENT;
                end
            end
            S_WAIT: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                    w_gap_nxt   = '0;
                end else if (r_gap == GAP_ONE) begin
                    w_data_nxt  = next_sample(r_data, r_mode, r_low, r_high);
                    w_state_nxt = S_PRESENT;
                    w_gap_nxt   = '0;
                end else begin
                    w_gap_nxt = r_gap - GAP_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gap_nxt   = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs; valid/busy are decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_gap   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_data  <= w_data_nxt;
            r_gap   <= w_gap_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_state_nxt == S_PRESENT);
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Run configuration, captured only when leaving IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode   <= 2'd0;
            r_period <= '0;
            r_low    <= '0;
            r_high   <= '0;
        end else if (w_load_cfg) begin
            r_mode   <= mode;
            r_period <= period;
            r_low    <= low_val;
            r_high   <= high_val;
        end else begin
            r_mode   <= r_mode;
            r_period <= r_period;
            r_low    <= r_low;
            r_high   <= r_high;
        end
    end

    assign strm.data   = r_data;
    assign strm.valid  = r_valid;
    assign busy        = r_busy;
    assign sample_cnt  = r_cnt;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen with a per-cycle stream model and literal spot checks.
module tb_pattern_gen;

    localparam int WIDTH    = 8;
    localparam int PERIOD_W = 8;
    localparam int CNT_W    = 4;
    localparam int STEP     = 2;

    logic                clk = 1'b0;
    logic                reset_n = 1'b1;
    logic                en = 1'b0;
    logic [1:0]          mode = 2'd0;
    logic [PERIOD_W-1:0] period = '0;
    logic [WIDTH-1:0]    low_val = '0;
    logic [WIDTH-1:0]    high_val = '0;
    logic                busy;
    logic [CNT_W-1:0]    sample_cnt;

    pattern_gen_if #(.WIDTH(WIDTH)) bus ();

    pattern_gen #(
        .WIDTH(WIDTH), .PERIOD_W(PERIOD_W), .CNT_W(CNT_W), .STEP(STEP), .TAPS(8'hB8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .period(period),
        .low_val(low_val), .high_val(high_val), .strm(bus),
        .busy(busy), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int m_mode, m_period, m_lo, m_hi, m_cur, m_cnt, m_idle;
    bit m_restart = 1'b0;
    bit m_after = 1'b0;
    bit prev_v = 1'b0;
    bit prev_r = 1'b0;
    int prev_d = 0;
    int acc_q[$];
    int acc_t[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_first(input int md, input int lo, input int hi);
        if (md == 2) return hi;
        if (md == 3 && lo == 0) return 1;
        return lo;
    endfunction

    function automatic int model_next(input int md, input int c, input int lo, input int hi);
        int n;
        case (md)
            0: n = (c == lo) ? hi : lo;
            1: n = (c + STEP > hi) ? lo : c + STEP;
            2: n = hi;
            default: begin
                n = ((c * 2) % 256) + ($countones(c & 'hB8) % 2);
                if (n == 0) n = 1;
            end
        endcase
        return n;
    endfunction

    // Stream model: expected data, gap length, counter and stall stability every cycle.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            chk("rst_valid", int'(bus.valid), 0);
            chk("rst_data", int'(bus.data), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_cnt", int'(sample_cnt), 0);
            m_cnt = 0;
            m_after = 1'b0;
            prev_v = 1'b0;
        end else begin
            chk("sample_cnt", int'(sample_cnt), m_cnt);
            if (prev_v && !prev_r) begin
                chk("stall_valid", int'(bus.valid), 1);
                chk("stall_data", int'(bus.data), prev_d);
            end
            if (bus.valid) begin
                if (m_restart) begin
                    m_cur = model_first(m_mode, m_lo, m_hi);
                    m_restart = 1'b0;
                    m_after = 1'b0;
                end
                if (m_after) begin
                    chk("gap_len", m_idle, m_period);
                    m_after = 1'b0;
                end
                chk("data", int'(bus.data), m_cur);
                chk("busy_when_valid", int'(busy), 1);
                if (bus.ready) begin
                    acc_q.push_back(int'(bus.data));
                    acc_t.push_back(cyc);
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    m_cur = model_next(m_mode, m_cur, m_lo, m_hi);
                    m_after = 1'b1;
                    m_idle = 0;
                end
            end else if (m_after) begin
                m_idle++;
            end
            prev_v = bus.valid;
            prev_r = bus.ready;
            prev_d = int'(bus.data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int md, input int p, input int lo, input int hi);
        mode = 2'(md);
        period = PERIOD_W'(p);
        low_val = WIDTH'(lo);
        high_val = WIDTH'(hi);
        m_mode = md;
        m_period = p;
        m_lo = lo;
        m_hi = hi;
        m_restart = 1'b1;
        acc_q.delete();
        acc_t.delete();
        en = 1'b1;
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while (acc_q.size() < n && k < 3000) begin
            tick();
            k++;
        end
        if (acc_q.size() < n) chk("wait_acc_timeout", acc_q.size(), n);
    endtask

    task automatic stop();
        int k = 0;
        en = 1'b0;
        bus.ready = 1'b1;
        while (busy && k < 50) begin
            tick();
            k++;
        end
        chk("stop_idle", int'(busy), 0);
    endtask

    task automatic expect4(input string name, input int a, input int b, input int c, input int d);
        int e[4];
        e = '{a, b, c, d};
        chk({name, "_count"}, acc_q.size(), 4);
        for (int i = 0; i < 4; i++) chk(name, acc_q[i], e[i]);
    endtask

    initial begin
        bit seen[256];
        int distinct;
        bus.ready = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // 1: TOGGLE 0/5 back-to-back, latency of one edge
        bus.ready = 1'b1;
        start(0, 0, 0, 5);
        chk("t1_valid_before_edge", int'(bus.valid), 0);
        tick();
        chk("t1_valid_latency", int'(bus.valid), 1);
        chk("t1_first_data", int'(bus.data), 0);
        wait_acc(3);
        stop();
        expect4("t1_toggle", 0, 5, 0, 5);
        chk("t1_sample_cnt", int'(sample_cnt), 4);

        // 2: RAMP wrap with STEP=2, then degenerate low==high
        start(1, 0, 250, 253);
        wait_acc(3);
        stop();
        expect4("t2_ramp", 250, 252, 250, 252);
        start(1, 0, 7, 7);
        wait_acc(3);
        stop();
        expect4("t2_ramp_const", 7, 7, 7, 7);

        // 3: TOGGLE with a 3-cycle gap: accepts 4 cycles apart
        start(0, 3, 1, 2);
        wait_acc(3);
        stop();
        chk("t3_count", acc_q.size(), 3);
        chk("t3_spacing_a", acc_t[1] - acc_t[0], 4);
        chk("t3_spacing_b", acc_t[2] - acc_t[1], 4);
        chk("t3_second", acc_q[1], 2);

        // 4: five-cycle stall, en dropped mid-stall, one final accept
        bus.ready = 1'b0;
        start(0, 0, 3, 9);
        tick();
        chk("t4_valid", int'(bus.valid), 1);
        repeat (2) tick();
        en = 1'b0;
        repeat (3) tick();
        chk("t4_hold_valid", int'(bus.valid), 1);
        chk("t4_hold_data", int'(bus.data), 3);
        chk("t4_hold_busy", int'(busy), 1);
        bus.ready = 1'b1;
        tick();
        chk("t4_idle_valid", int'(bus.valid), 0);
        chk("t4_idle_busy", int'(busy), 0);
        chk("t4_one_accept", acc_q.size(), 1);

        // 5: LFSR from seed 0, mode input changed mid-run has no effect
        start(3, 0, 0, 0);
        wait_acc(5);
        mode = 2'd2;
        wait_acc(256);
        stop();
        chk("t5_s0", acc_q[0], 1);
        chk("t5_s1", acc_q[1], 2);
        chk("t5_s2", acc_q[2], 4);
        chk("t5_s3", acc_q[3], 8);
        chk("t5_s4", acc_q[4], 17);
        distinct = 0;
        for (int i = 0; i < 255; i++) begin
            if (!seen[acc_q[i]]) distinct++;
            seen[acc_q[i]] = 1'b1;
        end
        chk("t5_distinct", distinct, 255);
        chk("t5_repeat", acc_q[255], acc_q[0]);
        start(2, 0, 0, 60);
        wait_acc(2);
        stop();
        chk("t5_hold_a", acc_q[0], 60);
        chk("t5_hold_b", acc_q[1], 60);

        // 6: asynchronous reset while stalled, then a 16-accept counter wrap
        start(0, 0, 17, 34);
        wait_acc(3);
        bus.ready = 1'b0;
        repeat (2) tick();
        chk("t6_stalled", int'(bus.valid), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(bus.valid), 0);
        chk("t6_rst_data", int'(bus.data), 0);
        chk("t6_rst_cnt", int'(sample_cnt), 0);
        en = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        bus.ready = 1'b1;
        start(2, 1, 0, 99);
        wait_acc(16);
        en = 1'b0;
        stop();
        chk("t6_wrap_count", acc_q.size(), 16);
        chk("t6_wrap_cnt", int'(sample_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
